// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access sequencer.
//   - req_op encodings, access-size and FSM state enums
//   - wait-counter width
//   - byte-enable and store-lane replication helpers
package mem_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] OP_WORD   = 3'd0;
  localparam logic [2:0] OP_BYTE_U = 3'd1;
  localparam logic [2:0] OP_BYTE_S = 3'd2;
  localparam logic [2:0] OP_HALF_U = 3'd3;
  localparam logic [2:0] OP_HALF_S = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Encodings 5-7 are not defined as narrow accesses and fall back to word.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      OP_BYTE_U, OP_BYTE_S: op_size = SZ_BYTE;
      OP_HALF_U, OP_HALF_S: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: lane_enables = 4'b0001 << a;
      SZ_HALF: lane_enables = a[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Store data is copied to every lane so the enabled lane always carries it.
  function automatic logic [31:0] lane_replicate(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: lane_replicate = {4{d[7:0]}};
      SZ_HALF: lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/half lane of a read word and
// zero- or sign-extends it to 32 bits.
// Ports:
//   op      in  3   latched req_op
//   addr_lo in  2   latched byte address bits [1:0]
//   rdata   in  32  captured bus read word
//   data    out 32  extended load result
module load_ext
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the low address bits.
  always_comb begin
    byte_s = 8'd0;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by operation type; unknown encodings return the full word.
  always_comb begin
    data = rdata;
    case (op)
      OP_BYTE_U: data = {24'd0, byte_s};
      OP_BYTE_S: data = {{24{byte_s[7]}}, byte_s};
      OP_HALF_U: data = {16'd0, half_s};
      OP_HALF_S: data = {{16{half_s[15]}}, half_s};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one MEM-stage load/store at a time onto a
// multi-cycle data bus, stalls the pipeline until ack or timeout, and
// returns extended load data with a one-cycle rd_valid pulse.
// Optional feature macro: DM_ALIGN_CHECK_EN (misaligned word/half accesses
// complete immediately with err_align instead of going to the bus).
// Ports:
//   clk, reset                      clock, async active-high reset
//   req_valid/we/op/addr/wdata      request from the MEM stage
//   stall                           pipeline freeze
//   bus_req/we/addr/byteen/wdata    bus command, held until ack/timeout
//   bus_ack, bus_rdata              bus completion and read word
//   rd_valid, rd_data               completion pulse and load result
//   err_timeout, err_align          error pulses coincident with rd_valid
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err_timeout,
  output logic        err_align
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(BUS_TIMEOUT);

  state_e            state_r, state_nxt;
  logic              we_r;
  logic [2:0]        op_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              abort_r;
  logic              align_r;
  logic              misalign_s;
  logic              in_bus_s;
  logic              in_done_s;
  logic              expire_s;
  logic [31:0]       ext_s;

  assign in_bus_s  = (state_r == ST_BUS);
  assign in_done_s = (state_r == ST_DONE);
  assign cnt_inc_s = cnt_r + 8'd1;
  // Timeout fires on the cycle the count would reach the limit; ack wins.
  assign expire_s  = (cnt_inc_s == TIMEOUT_C);

`ifdef DM_ALIGN_CHECK_EN
  // Misalignment decode for the incoming request.
  always_comb begin
    misalign_s = 1'b0;
    case (op_size(req_op))
      SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
      SZ_HALF: misalign_s = req_addr[0];
      default: misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = misalign_s ? ST_DONE : ST_BUS;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_ack || expire_s) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_BUS;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, read capture and completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      op_r    <= 3'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      cnt_r   <= '0;
      abort_r <= 1'b0;
      align_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= '0;
          abort_r <= 1'b0;
          rdata_r <= 32'd0;
          if (req_valid) begin
            we_r    <= req_we;
            op_r    <= req_op;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            align_r <= misalign_s;
          end else begin
            align_r <= 1'b0;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            rdata_r <= bus_rdata;
          end else begin
            cnt_r <= cnt_inc_s;
            if (expire_s) begin
              abort_r <= 1'b1;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  load_ext u_load_ext (
    .op      (op_r),
    .addr_lo (addr_r[1:0]),
    .rdata   (rdata_r),
    .data    (ext_s)
  );

  assign stall       = ((state_r == ST_IDLE) && req_valid) || in_bus_s;
  assign bus_req     = in_bus_s;
  assign bus_we      = in_bus_s & we_r;
  assign bus_addr    = in_bus_s ? {addr_r[31:2], 2'b00} : 32'd0;
  assign bus_byteen  = in_bus_s ? lane_enables(op_size(op_r), addr_r[1:0]) : 4'b0000;
  assign bus_wdata   = (in_bus_s && we_r) ? lane_replicate(op_size(op_r), wdata_r) : 32'd0;
  assign rd_valid    = in_done_s;
  assign rd_data     = (in_done_s && !we_r && !abort_r && !align_r) ? ext_s : 32'd0;
  assign err_timeout = in_done_s & abort_r;
  assign err_align   = in_done_s & align_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err_timeout, err_align;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.BUS_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .err_timeout(err_timeout), .err_align(err_align)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-access observations.
  int          n_stall, n_req;
  logic        o_valid, o_to, o_al, o_we;
  logic [31:0] o_rd, o_addr, o_wd;
  logic [3:0]  o_be;
  logic        o_done;

  // Runs one access starting in an IDLE cycle (called #1 after a posedge).
  // ack_k < 0 means the bus never acks.
  task automatic do_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_k, input logic [31:0] rdata);
    n_stall = 0; n_req = 0; o_valid = 0; o_to = 0; o_al = 0; o_we = 0;
    o_rd = 32'hX; o_addr = 32'd0; o_wd = 32'd0; o_be = 4'd0; o_done = 0;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    #1;
    if (stall) n_stall++;
    for (int c = 1; c < 40 && !o_done; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = 32'd0;
      if (bus_req) begin
        n_req++;
        if (n_req == 1) begin
          o_addr = bus_addr; o_be = bus_byteen; o_wd = bus_wdata; o_we = bus_we;
        end
        if (ack_k >= 0 && n_req == ack_k + 1) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
      end
      #1;
      if (stall) n_stall++;
      if (rd_valid) begin
        o_done = 1; o_valid = 1; o_rd = rd_data; o_to = err_timeout; o_al = err_align;
      end
    end
    check_eq("access_completes", {31'd0, o_done}, 32'd1);
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  logic seen_valid;

  initial begin
    reset = 1'b1; req_valid = 0; req_we = 0; req_op = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; bus_ack = 0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word load, ack after 2 cycles.
    do_access(1'b0, 3'd0, 32'h0000_0100, 32'd0, 2, 32'hDEAD_BEEF);
    check_eq("lw_stall_cycles", n_stall, 32'd4);
    check_eq("lw_req_cycles", n_req, 32'd3);
    check_eq("lw_rd_data", o_rd, 32'hDEAD_BEEF);
    check_eq("lw_be", {28'd0, o_be}, 32'hF);
    check_eq("lw_addr", o_addr, 32'h0000_0100);
    check_eq("lw_we", {31'd0, o_we}, 32'd0);

    // Signed and unsigned byte loads from lane 3.
    do_access(1'b0, 3'd2, 32'h0000_0103, 32'd0, 0, 32'h80FF_0000);
    check_eq("lbs_be", {28'd0, o_be}, 32'h8);
    check_eq("lbs_rd_data", o_rd, 32'hFFFF_FF80);
    check_eq("lbs_stall_cycles", n_stall, 32'd2);
    do_access(1'b0, 3'd1, 32'h0000_0103, 32'd0, 1, 32'h80FF_0000);
    check_eq("lbu_rd_data", o_rd, 32'h0000_0080);

    // Half loads.
    do_access(1'b0, 3'd3, 32'h0000_0002, 32'd0, 0, 32'h8001_0000);
    check_eq("lhu_rd_data", o_rd, 32'h0000_8001);
    check_eq("lhu_be", {28'd0, o_be}, 32'hC);
    do_access(1'b0, 3'd4, 32'h0000_0000, 32'd0, 0, 32'h0000_8001);
    check_eq("lhs_rd_data", o_rd, 32'hFFFF_8001);
    check_eq("lhs_be", {28'd0, o_be}, 32'h3);

    // Half store.
    do_access(1'b1, 3'd3, 32'h0000_2002, 32'h1234_ABCD, 0, 32'h5555_5555);
    check_eq("sh_addr", o_addr, 32'h0000_2000);
    check_eq("sh_be", {28'd0, o_be}, 32'hC);
    check_eq("sh_wdata", o_wd, 32'hABCD_ABCD);
    check_eq("sh_we", {31'd0, o_we}, 32'd1);
    check_eq("sh_rd_data", o_rd, 32'd0);

    // Byte store to lane 1.
    do_access(1'b1, 3'd1, 32'h0000_0041, 32'h0000_0055, 0, 32'd0);
    check_eq("sb_be", {28'd0, o_be}, 32'h2);
    check_eq("sb_wdata", o_wd, 32'h5555_5555);

    // Timeout: no ack.
    do_access(1'b0, 3'd0, 32'h0000_0200, 32'd0, -1, 32'd0);
    check_eq("to_req_cycles", n_req, 32'd15);
    check_eq("to_err", {31'd0, o_to}, 32'd1);
    check_eq("to_rd_data", o_rd, 32'd0);

    // Ack in the 15th bus cycle is a success.
    do_access(1'b0, 3'd0, 32'h0000_0200, 32'd0, 14, 32'hCAFE_F00D);
    check_eq("ack15_req_cycles", n_req, 32'd15);
    check_eq("ack15_err", {31'd0, o_to}, 32'd0);
    check_eq("ack15_rd_data", o_rd, 32'hCAFE_F00D);

    // Misaligned word load.
    do_access(1'b0, 3'd0, 32'h0000_0101, 32'd0, 0, 32'h1111_2222);
`ifdef DM_ALIGN_CHECK_EN
    check_eq("mis_req_cycles", n_req, 32'd0);
    check_eq("mis_err_align", {31'd0, o_al}, 32'd1);
    check_eq("mis_rd_data", o_rd, 32'd0);
    check_eq("mis_stall_cycles", n_stall, 32'd1);
`else
    check_eq("mis_addr", o_addr, 32'h0000_0100);
    check_eq("mis_be", {28'd0, o_be}, 32'hF);
    check_eq("mis_err_align", {31'd0, o_al}, 32'd0);
    check_eq("mis_rd_data", o_rd, 32'h1111_2222);
`endif

    // Reset during BUS, then a late ack.
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_bus_req_before", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    seen_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      seen_valid = seen_valid | rd_valid | bus_req | stall;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    check_eq("late_ack_ignored", {31'd0, seen_valid}, 32'd0);

    // Controller is back in IDLE and serves a new access.
    do_access(1'b0, 3'd0, 32'h0000_0400, 32'd0, 0, 32'h0BAD_F00D);
    check_eq("post_rst_rd_data", o_rd, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the MEM pipeline stage and a multi-cycle data-memory bus. Takes one load/store request at a time, builds word-aligned bus address, byte enables and lane-replicated store data, and stalls the pipeline until the bus acknowledges. It then sign- or zero-extends load data and returns it. A wait-cycle counter aborts hung transactions.

## Interface
- BUS_TIMEOUT, 15, maximum cycles `bus_req` stays high without `bus_ack` (legal 1..255)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage presents an access this cycle
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  width/extension: 0 word, 1 byte unsigned, 2 byte signed, 3 half unsigned, 4 half signed; stores treat 1/2 as byte, 3/4 as half; 5-7 behave as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- stall  out  1  freeze pipeline
- bus_req  out  1  bus request, held until ack or timeout
- bus_we  out  1  bus write
- bus_addr  out  32  {req_addr[31:2], 2'b00}
- bus_byteen  out  4  lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle completion from bus
- bus_rdata  in  32  read word, valid with `bus_ack`
- rd_valid  out  1  one-cycle completion pulse
- rd_data  out  32  extended load data (0 for stores/aborts)
- err_timeout  out  1  one-cycle pulse with `rd_valid` on abort
- err_align  out  1  one-cycle pulse with `rd_valid` on misaligned access (see Configuration)

## Operation
- States: IDLE, BUS, DONE.
- IDLE: on `req_valid`, latch we/op/addr/wdata and go to BUS. Clear the wait counter.
- BUS: `bus_req`=1 and bus_* driven from latched values.
  - If `bus_ack` arrives, capture `bus_rdata` and go to DONE.
  - Otherwise increment the counter. When the counter reaches BUS_TIMEOUT without ack, go to DONE with the abort flag set.
  - An ack in the same cycle the count reaches BUS_TIMEOUT is a success, not a timeout.
- DONE: `rd_valid`=1, `stall`=0, `rd_data` valid. Go to IDLE unconditionally. `req_valid` seen in DONE is the retiring request and is ignored.
- `stall` = (IDLE & req_valid) | BUS.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: unchanged
- Load extension:
  - byte: select lane addr[1:0]
  - half: select lane addr[1]
  - Zero- or sign-extend per `req_op` to 32 bits.
- Stores return `rd_data`=0.
- `bus_ack` outside BUS is ignored.

## Timing
- Reset (async): state IDLE, counter 0, all outputs 0. `bus_req` drops immediately, including mid-transaction. A late ack after reset is ignored.
- `stall` is combinational from `req_valid`. All other outputs are registered or decoded from state/latched registers.
- Latency with ack k cycles after `bus_req` rises (k≥0):
  - request accepted in cycle 0
  - `bus_req` high cycles 1..1+k
  - DONE in cycle 2+k
- Minimum occupancy is 3 cycles per access. Back-to-back requests are accepted from IDLE the cycle after DONE.
- Timeout:
  - `bus_req` high exactly BUS_TIMEOUT cycles
  - DONE follows with `err_timeout`=1 and `rd_data`=0

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - A word with addr[1:0]≠0, or a half with addr[0]≠0, goes IDLE→DONE directly.
  - No bus transaction; `bus_req` never rises.
  - DONE pulses `err_align`=1 with `rd_data`=0.
- Undefined: no check. Low address bits outside the lane select are ignored and `err_align` is tied 0.

## Structure
- Package `mem_pkg`:
  - `req_op` encodings
  - state encoding
  - byte-enable and lane-replication functions
  - counter width constant (8)
- One sub-module, `load_ext`: combinational lane select plus zero/sign extension of the captured read word, driven by latched op and addr[1:0].

## Test plan
- Load word, addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF → `stall` high 4 cycles; DONE has rd_data 0xDEADBEEF, rd_valid=1.
- Signed byte load, addr 0x103, rdata 0x80FF0000 → byteen 1000, rd_data 0xFFFFFF80. Unsigned byte load → 0x00000080.
- Half store 0x1234ABCD at addr 0x2002 → bus_addr 0x2000, byteen 1100, bus_wdata 0xABCDABCD, bus_we=1.
- No ack, BUS_TIMEOUT=15 → `bus_req` high 15 cycles, then err_timeout=1, rd_data=0. Ack in cycle 15 instead → success.
- Reset asserted during BUS, then ack → `bus_req` 0 immediately, no rd_valid, state IDLE.
- With `DM_ALIGN_CHECK_EN`: word load at 0x101 → bus_req never 1, err_align=1 in cycle 1. Without it: bus_addr 0x100, byteen 1111.
